pixel_feeder: RTL and testbench

Upstream stage of the MNIST accelerator core. It collects one 28×28 image (784 pixels) from a byte-wide valid/ready source into a local frame buffer, then streams it into the core as 784 gap-free `i_valid` beats. It then holds off further input until the core returns its `o_valid`/`digit` result. It latches the result and counts completed frames, so only one image is ever in flight in the core.

---
 rtl/core_pkg.sv | 14 +
 rtl/pixel_feeder_if.sv | 29 ++
 rtl/frame_buffer.sv | 44 ++++
 rtl/pixel_feeder.sv | 131 +++++++++++++
 tb/tb_pixel_feeder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared constants and types for the MNIST accelerator core and its pixel feeder.
package core_pkg;

    localparam int NUM_PIXELS  = 784;
    localparam int DIGIT_WIDTH = 4;
    localparam int ADDR_WIDTH  = $clog2(NUM_PIXELS);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/pixel_feeder_if.sv
// Source handshake, core-side stream and result signals of the pixel feeder.
interface pixel_feeder_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int DIGIT_WIDTH = 4
);
    logic                   s_valid;
    logic                   s_ready;
    logic [DATA_WIDTH-1:0]  s_pixel;
    logic                   i_valid;
    logic [DATA_WIDTH-1:0]  pixel;
    logic                   core_o_valid;
    logic [DIGIT_WIDTH-1:0] core_digit;
    logic                   result_valid;
    logic [DIGIT_WIDTH-1:0] result;
    logic                   busy;
    logic [15:0]            frame_count;

    // Environment side: pixel source plus the core's result outputs.
    modport master (
        output s_valid, s_pixel, core_o_valid, core_digit,
        input  s_ready, i_valid, pixel, result_valid, result, busy, frame_count
    );

    // Feeder side.
    modport slave (
        input  s_valid, s_pixel, core_o_valid, core_digit,
        output s_ready, i_valid, pixel, result_valid, result, busy, frame_count
    );
endinterface

// File: rtl/frame_buffer.sv
// Single-port frame RAM with a registered read; the array itself has no reset.
module frame_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 784,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data only moves on a read, so the stream output holds between frames.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pixel_feeder.sv
// Buffers one image from a valid/ready source, streams it gap-free to the core,
// then waits for the core's digit before accepting the next image.
module pixel_feeder #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_PIXELS  = core_pkg::NUM_PIXELS,
    parameter int DIGIT_WIDTH = core_pkg::DIGIT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    pixel_feeder_if.slave  bus
);
    import core_pkg::*;

    localparam int             AW        = $clog2(NUM_PIXELS);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(NUM_PIXELS - 1);

    feeder_state_t          state_q, state_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [AW-1:0]          rd_addr_q, rd_addr_d;
    logic                   i_valid_q, i_valid_d;
    logic [DIGIT_WIDTH-1:0] result_q, result_d;
    logic                   result_valid_q, result_valid_d;
    logic [15:0]            frame_count_q, frame_count_d;

    logic                   s_ready;
    logic                   load_hs;
    logic                   ram_we;
    logic                   ram_re;
    logic [AW-1:0]          ram_addr;
    logic [DATA_WIDTH-1:0]  ram_rdata;

    // Ready is masked during reset so nothing is accepted in the reset cycle.
    assign s_ready = (state_q == LOAD) && !rst;
    assign load_hs = bus.s_valid && s_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (load_hs && (wr_addr_q == LAST_ADDR)) state_d = STREAM;
            STREAM:  if (rd_addr_q == LAST_ADDR)              state_d = WAIT;
            WAIT:    if (bus.core_o_valid)                    state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        wr_addr_d      = wr_addr_q;
        rd_addr_d      = rd_addr_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        frame_count_d  = frame_count_q;
        i_valid_d      = (state_q == STREAM);
        ram_we         = 1'b0;
        ram_re         = 1'b0;
        ram_addr       = wr_addr_q;
        case (state_q)
            LOAD: begin
                if (load_hs) begin
                    ram_we    = 1'b1;
                    wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + 1'b1;
                end
            end
            STREAM: begin
                ram_re    = 1'b1;
                ram_addr  = rd_addr_q;
                rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;
            end
            WAIT: begin
                if (bus.core_o_valid) begin
                    result_d       = bus.core_digit;
                    result_valid_d = 1'b1;
                    frame_count_d  = frame_count_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            i_valid_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            i_valid_q      <= i_valid_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            frame_count_q  <= frame_count_d;
        end
    end

    // i_valid is delayed one cycle to line up with the registered RAM read.
    frame_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (NUM_PIXELS),
        .ADDR_WIDTH (AW)
    ) u_frame_buffer (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (bus.s_pixel),
        .rdata (ram_rdata)
    );

    assign bus.s_ready      = s_ready;
    assign bus.i_valid      = i_valid_q;
    assign bus.pixel        = ram_rdata;
    assign bus.result_valid = result_valid_q;
    assign bus.result       = result_q;
    assign bus.busy         = (state_q != LOAD);
    assign bus.frame_count  = frame_count_q;

endmodule

// File: tb/tb_pixel_feeder.sv
// Directed bench for pixel_feeder: table of whole-frame vectors plus
// hand-written reset and counter-wrap sequences.
module tb_pixel_feeder;
    import core_pkg::*;

    localparam int NP = 784;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_feeder_if #(.DATA_WIDTH(8), .DIGIT_WIDTH(4)) bus ();

    pixel_feeder #(
        .DATA_WIDTH  (8),
        .NUM_PIXELS  (NP),
        .DIGIT_WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0]  m_result;
    logic [15:0] m_count;

    typedef struct {
        int         duty;
        logic [7:0] offset;
        bit         spur_load;
        bit         spur_stream;
        logic [3:0] digit;
        logic [3:0] exp_result;
        logic [15:0] exp_count;
    } frame_vec_t;

    frame_vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Loads 'count' pixels; returns at the negedge of the cycle after the last handshake.
    task automatic load_frame(input int duty, input logic [7:0] offset, input bit spur_load,
                              input int count, output bit ok);
        int n = 0;
        int cyc = 0;
        ok = 1'b1;
        while (n < count) begin
            @(negedge clk);
            bus.core_o_valid = 1'b0;
            if (cyc > 20000) begin
                check("load_timeout", 32'(n), 32'(count));
                ok = 1'b0;
                break;
            end
            bus.s_valid = ($urandom_range(99) < duty);
            bus.s_pixel = 8'(n) + offset;
            if (spur_load && n == 300) begin
                bus.core_o_valid = 1'b1;
                bus.core_digit   = 4'hA;
            end
            if (bus.s_valid && bus.s_ready) n++;
            cyc++;
        end
        @(negedge clk);
        bus.s_valid      = 1'b0;
        bus.core_o_valid = 1'b0;
    endtask

    // Entered at cycle k+1; leaves at cycle k+786 (WAIT, stream done).
    task automatic stream_check(input logic [7:0] offset, input bit spur_stream);
        logic [7:0] e;
        check("s_ready_drop", 32'(bus.s_ready), 0);
        check("k1_i_valid", 32'(bus.i_valid), 0);
        check("busy_stream", 32'(bus.busy), 1);
        check("load_result_hold", 32'(bus.result), 32'(m_result));
        check("load_count_hold", 32'(bus.frame_count), 32'(m_count));
        for (int j = 0; j < NP; j++) begin
            @(negedge clk);
            bus.core_o_valid = spur_stream && (j == 100);
            bus.core_digit   = 4'h3;
            e = 8'(j) + offset;
            check("i_valid_beat", 32'(bus.i_valid), 1);
            check("pixel_beat", 32'(bus.pixel), 32'(e));
            check("no_result_pulse", 32'(bus.result_valid), 0);
        end
        @(negedge clk);
        bus.core_o_valid = 1'b0;
        check("i_valid_end", 32'(bus.i_valid), 0);
        check("busy_wait", 32'(bus.busy), 1);
        check("stream_result_hold", 32'(bus.result), 32'(m_result));
        check("stream_count_hold", 32'(bus.frame_count), 32'(m_count));
    endtask

    task automatic finish_result(input logic [3:0] digit, input logic [3:0] exp_result,
                                 input logic [15:0] exp_count);
        repeat (3) begin
            @(negedge clk);
            check("wait_s_ready", 32'(bus.s_ready), 0);
        end
        bus.core_o_valid = 1'b1;
        bus.core_digit   = digit;
        @(negedge clk);
        bus.core_o_valid = 1'b0;
        check("result_valid_pulse", 32'(bus.result_valid), 1);
        check("result_value", 32'(bus.result), 32'(exp_result));
        check("frame_count", 32'(bus.frame_count), 32'(exp_count));
        check("s_ready_after", 32'(bus.s_ready), 1);
        check("busy_after", 32'(bus.busy), 0);
        @(negedge clk);
        check("result_valid_one", 32'(bus.result_valid), 0);
        check("result_held", 32'(bus.result), 32'(exp_result));
        m_result = exp_result;
        m_count  = exp_count;
    endtask

    task automatic run_frame(input frame_vec_t v);
        bit ok;
        load_frame(v.duty, v.offset, v.spur_load, NP, ok);
        if (ok) begin
            stream_check(v.offset, v.spur_stream);
            finish_result(v.digit, v.exp_result, v.exp_count);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"}, 32'(bus.s_ready), 0);
        check({tag, "_i_valid"}, 32'(bus.i_valid), 0);
        check({tag, "_pixel"}, 32'(bus.pixel), 0);
        check({tag, "_result_valid"}, 32'(bus.result_valid), 0);
        check({tag, "_result"}, 32'(bus.result), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_frame_count"}, 32'(bus.frame_count), 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_vec_t fv;
        bit ok;

        vecs[0] = '{duty: 100, offset: 8'd0,   spur_load: 1'b0, spur_stream: 1'b0,
                    digit: 4'd7,  exp_result: 4'd7,  exp_count: 16'd1};
        vecs[1] = '{duty: 30,  offset: 8'd0,   spur_load: 1'b0, spur_stream: 1'b0,
                    digit: 4'd2,  exp_result: 4'd2,  exp_count: 16'd2};
        vecs[2] = '{duty: 100, offset: 8'd37,  spur_load: 1'b1, spur_stream: 1'b1,
                    digit: 4'd5,  exp_result: 4'd5,  exp_count: 16'd3};
        vecs[3] = '{duty: 60,  offset: 8'd200, spur_load: 1'b1, spur_stream: 1'b1,
                    digit: 4'd15, exp_result: 4'd15, exp_count: 16'd4};

        bus.s_valid      = 1'b0;
        bus.s_pixel      = '0;
        bus.core_o_valid = 1'b0;
        bus.core_digit   = '0;
        m_result         = '0;
        m_count          = '0;

        // Power-on reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst = 1'b0;
        @(negedge clk);
        check("por_s_ready_up", 32'(bus.s_ready), 1);

        foreach (vecs[i]) run_frame(vecs[i]);

        // Reset with a partial frame loaded
        load_frame(100, 8'd11, 1'b0, 400, ok);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("load_rst");
        rst = 1'b0;
        m_result = '0;
        m_count  = '0;
        @(negedge clk);
        check("load_rst_s_ready_up", 32'(bus.s_ready), 1);
        fv = '{duty: 100, offset: 8'd90, spur_load: 1'b0, spur_stream: 1'b0,
               digit: 4'd3, exp_result: 4'd3, exp_count: 16'd1};
        run_frame(fv);

        // Reset during streaming
        load_frame(100, 8'd5, 1'b0, NP, ok);
        repeat (50) @(negedge clk);
        check("mid_stream_i_valid", 32'(bus.i_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        check("stream_rst_i_valid", 32'(bus.i_valid), 0);
        check("stream_rst_busy", 32'(bus.busy), 0);
        check("stream_rst_pixel", 32'(bus.pixel), 0);
        check("stream_rst_count", 32'(bus.frame_count), 0);
        rst = 1'b0;
        m_result = '0;
        m_count  = '0;
        @(negedge clk);
        check("stream_rst_s_ready_up", 32'(bus.s_ready), 1);

        // Frame counter wrap
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_q;
        @(negedge clk);
        check("wrap_preload", 32'(bus.frame_count), 32'hFFFF);
        m_count = 16'hFFFF;
        fv = '{duty: 100, offset: 8'd128, spur_load: 1'b0, spur_stream: 1'b0,
               digit: 4'd9, exp_result: 4'd9, exp_count: 16'h0000};
        run_frame(fv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
